// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin N-to-1 stream arbiter feeding a
// one-entry registered output buffer (1-cycle latency, full throughput).
module stream_rr_arbiter #(
   parameter int p_num_reqs = 4,
   parameter int p_msg_bits = 32
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [p_num_reqs-1:0][p_msg_bits-1:0] req_msg,
   input  logic [p_num_reqs-1:0]                 req_val,
   output logic [p_num_reqs-1:0]                 req_rdy,
   output logic [p_msg_bits-1:0]                 out_msg,
   output logic [$clog2(p_num_reqs)-1:0]         out_id,
   output logic                                  out_val,
   input  logic                                  out_rdy
);

   localparam int IW = $clog2(p_num_reqs);
   localparam logic [IW-1:0] LAST = IW'(p_num_reqs - 1);

   logic                  full_q, full_d;
   logic [p_msg_bits-1:0] msg_q, msg_d;
   logic [IW-1:0]         id_q, id_d;
   logic [IW-1:0]         ptr_q, ptr_d;

   logic          accept;
   logic          gnt_found;
   logic [IW-1:0] gnt_idx;

   // Buffer can take a new message when empty or draining this cycle.
   assign accept = rst & (~full_q | out_rdy);

   // Walk from the highest offset down so the closest match to ptr wins.
   always_comb begin
      int j;
      j         = 0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = p_num_reqs - 1; k >= 0; k--) begin
         j = int'(ptr_q) + k;
         if (j >= p_num_reqs) j = j - p_num_reqs;
         if (req_val[j]) begin
            gnt_found = 1'b1;
            gnt_idx   = IW'(j);
         end
      end
   end

   always_comb begin
      req_rdy = '0;
      if (accept && gnt_found) req_rdy[gnt_idx] = 1'b1;
   end

   always_comb begin
      full_d = full_q;
      msg_d  = msg_q;
      id_d   = id_q;
      ptr_d  = ptr_q;
      if (full_q && out_rdy) full_d = 1'b0;
      if (accept && gnt_found) begin
         full_d = 1'b1;
         msg_d  = req_msg[gnt_idx];
         id_d   = gnt_idx;
         ptr_d  = (gnt_idx == LAST) ? '0 : IW'(gnt_idx + 1'b1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         full_q <= 1'b0;
         msg_q  <= '0;
         id_q   <= '0;
         ptr_q  <= '0;
      end else begin
         full_q <= full_d;
         msg_q  <= msg_d;
         id_q   <= id_d;
         ptr_q  <= ptr_d;
      end
   end

   assign out_val = full_q & rst;
   assign out_msg = msg_q;
   assign out_id  = id_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: directed + randomised checks of stream_rr_arbiter
// against a queue-based behavioural model.
module tb_stream_rr_arbiter;

   localparam int N = 4;
   localparam int W = 32;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N-1:0][W-1:0]  req_msg;
   logic [N-1:0]         req_val;
   logic [N-1:0]         req_rdy;
   logic [W-1:0]         out_msg;
   logic [1:0]           out_id;
   logic                 out_val;
   logic                 out_rdy;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // behavioural model state
   bit          mfull = 1'b0;
   logic [31:0] mmsg  = '0;
   int          mid   = 0;
   int          mptr  = 0;
   logic [31:0] q [N][$];
   int          wcnt [N];
   int          recv_total = 0;

   stream_rr_arbiter #(.p_num_reqs(N), .p_msg_bits(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .req_msg (req_msg),
      .req_val (req_val),
      .req_rdy (req_rdy),
      .out_msg (out_msg),
      .out_id  (out_id),
      .out_val (out_val),
      .out_rdy (out_rdy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Which requester the spec's rules grant this cycle, or -1.
   function automatic int exp_grant();
      int j;
      if (!rst) return -1;
      if (mfull && !out_rdy) return -1;
      for (int k = 0; k < N; k++) begin
         j = (mptr + k) % N;
         if (req_val[j]) return j;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      int g;
      g = exp_grant();
      if (!rst) begin
         mfull = 1'b0;
         mptr  = 0;
         mmsg  = '0;
         mid   = 0;
         for (int i = 0; i < N; i++) begin
            q[i].delete();
            wcnt[i] = 0;
         end
      end else if (g >= 0) begin
         q[g].push_back(req_msg[g]);
         mfull = 1'b1;
         mmsg  = req_msg[g];
         mid   = g;
         mptr  = (g + 1) % N;
      end else if (mfull && out_rdy) begin
         mfull = 1'b0;
      end
   end

   always @(negedge clk) begin
      int g;
      logic [31:0] e_rdy;
      logic [31:0] front;
      bit acc;
      if (chk_en) begin
         g = exp_grant();
         e_rdy = (g >= 0) ? (32'd1 << g) : 32'd0;
         chk("req_rdy", 32'(req_rdy), e_rdy);
         chk("out_val", 32'(out_val), 32'(rst && mfull));
         if (rst && mfull) begin
            chk("out_msg", out_msg, mmsg);
            chk("out_id", 32'(out_id), 32'(mid));
         end
         if (out_val && out_rdy) begin
            recv_total++;
            if (q[out_id].size() == 0) begin
               chk("drain_extra", 32'(out_id), 32'hFFFF_FFFF);
            end else begin
               front = q[out_id].pop_front();
               chk("drain_order", out_msg, front);
            end
         end
         acc = rst && (!mfull || out_rdy);
         for (int i = 0; i < N; i++) begin
            if (!req_val[i] || !rst) begin
               wcnt[i] = 0;
            end else if (acc) begin
               if (req_rdy[i]) begin
                  chk("starve", 32'(wcnt[i] < N), 32'd1);
                  wcnt[i] = 0;
               end else begin
                  wcnt[i]++;
                  if (wcnt[i] >= N) begin
                     chk("starve_wait", 32'(wcnt[i]), 32'(N - 1));
                     wcnt[i] = 0;
                  end
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid_cyc();
      @(negedge clk);
   endtask

   initial begin
      bit   fire [N];
      bit   sfire;
      int   seq [N];
      int   dly [N];
      int   sdly;
      int   sent;
      int   cyc;
      int   recv0;

      rst     = 1'b0;
      req_val = 4'hF;
      out_rdy = 1'b1;
      for (int i = 0; i < N; i++) req_msg[i] = 32'h100 + 32'(i);
      tick();
      chk_en = 1'b1;

      // reset holds ready and valid low
      for (int k = 0; k < 2; k++) begin
         mid_cyc();
         chk("rst_rdy", 32'(req_rdy), 32'h0);
         chk("rst_val", 32'(out_val), 32'h0);
         tick();
      end
      rst = 1'b1;
      mid_cyc();
      chk("first_gnt", 32'(req_rdy), 32'h1);
      tick();

      // all valid, full throughput round robin
      for (int k = 0; k < 8; k++) begin
         mid_cyc();
         chk("rr_val", 32'(out_val), 32'h1);
         chk("rr_id", 32'(out_id), 32'(k % 4));
         chk("rr_msg", out_msg, 32'h100 + 32'(k % 4));
         chk("rr_rdy", 32'(req_rdy), 32'd1 << ((k + 1) % 4));
         tick();
      end

      // reset while the buffer is full discards it
      rst = 1'b0;
      mid_cyc();
      chk("midrst_val", 32'(out_val), 32'h0);
      chk("midrst_rdy", 32'(req_rdy), 32'h0);
      tick();

      // backpressure
      rst        = 1'b1;
      req_val    = 4'b0010;
      req_msg[1] = 32'hA;
      out_rdy    = 1'b0;
      mid_cyc();
      chk("bp_fill", 32'(req_rdy), 32'b0010);
      tick();
      req_val    = 4'b0101;
      req_msg[0] = 32'hC0;
      req_msg[2] = 32'hC2;
      for (int k = 0; k < 3; k++) begin
         mid_cyc();
         chk("bp_val", 32'(out_val), 32'h1);
         chk("bp_msg", out_msg, 32'hA);
         chk("bp_id", 32'(out_id), 32'h1);
         chk("bp_rdy", 32'(req_rdy), 32'h0);
         tick();
      end
      out_rdy = 1'b1;
      mid_cyc();
      chk("bp_refill", 32'(req_rdy), 32'b0100);
      chk("bp_msg2", out_msg, 32'hA);
      tick();
      mid_cyc();
      chk("bp_next_id", 32'(out_id), 32'h2);
      chk("bp_next_msg", out_msg, 32'hC2);
      chk("bp_next_rdy", 32'(req_rdy), 32'b0001);
      tick();

      // pointer skip and wrap
      rst = 1'b0;
      mid_cyc();
      tick();
      rst     = 1'b1;
      req_val = 4'b0010;
      mid_cyc();
      chk("skip_g1", 32'(req_rdy), 32'b0010);
      tick();
      req_val    = 4'b1001;
      req_msg[0] = 32'h50;
      req_msg[3] = 32'h53;
      mid_cyc();
      chk("skip_g3", 32'(req_rdy), 32'b1000);
      tick();
      mid_cyc();
      chk("skip_id3", 32'(out_id), 32'h3);
      chk("skip_msg3", out_msg, 32'h53);
      chk("wrap_g0", 32'(req_rdy), 32'b0001);
      tick();

      // idle, then a single request
      req_val = 4'b0000;
      mid_cyc();
      chk("wrap_id0", 32'(out_id), 32'h0);
      chk("wrap_msg0", out_msg, 32'h50);
      tick();
      for (int k = 0; k < 5; k++) begin
         mid_cyc();
         chk("idle_val", 32'(out_val), 32'h0);
         chk("idle_rdy", 32'(req_rdy), 32'h0);
         tick();
      end
      req_val    = 4'b0100;
      req_msg[2] = 32'hDEADBEEF;
      mid_cyc();
      chk("single_rdy", 32'(req_rdy), 32'b0100);
      tick();
      req_val = 4'b1111;
      mid_cyc();
      chk("single_val", 32'(out_val), 32'h1);
      chk("single_id", 32'(out_id), 32'h2);
      chk("single_msg", out_msg, 32'hDEADBEEF);
      chk("single_ptr", 32'(req_rdy), 32'b1000);
      tick();

      // randomised traffic
      rst     = 1'b0;
      req_val = '0;
      tick();
      rst  = 1'b1;
      sent = 0;
      cyc  = 0;
      sdly = 0;
      out_rdy = 1'b1;
      recv0 = recv_total;
      for (int i = 0; i < N; i++) begin
         seq[i] = 0;
         dly[i] = 0;
         req_val[i] = 1'b1;
         req_msg[i] = (32'(i) << 28);
      end
      while (sent < 1000 && cyc < 20000) begin
         mid_cyc();
         for (int i = 0; i < N; i++) fire[i] = req_val[i] & req_rdy[i];
         sfire = out_val & out_rdy;
         tick();
         cyc++;
         for (int i = 0; i < N; i++) begin
            if (fire[i]) begin
               sent++;
               seq[i]++;
               dly[i] = int'($urandom_range(0, 3));
            end
            if (fire[i] || !req_val[i]) begin
               if (sent >= 1000) begin
                  req_val[i] = 1'b0;
               end else if (dly[i] == 0) begin
                  req_val[i] = 1'b1;
                  req_msg[i] = (32'(i) << 28) | 32'(seq[i]);
               end else begin
                  req_val[i] = 1'b0;
                  dly[i]--;
               end
            end
         end
         if (sfire) sdly = int'($urandom_range(0, 3));
         if (sdly == 0) begin
            out_rdy = 1'b1;
         end else begin
            out_rdy = 1'b0;
            sdly--;
         end
      end
      req_val = '0;
      out_rdy = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      chk("rnd_sent", 32'(sent >= 1000), 32'h1);
      chk("rnd_recv", 32'(recv_total - recv0), 32'(sent));
      for (int i = 0; i < N; i++) chk("rnd_left", 32'(q[i].size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 Parameter p_num_reqs, default 4: number of requester streams; legal range 2..16.
REQ-002 Parameter p_msg_bits, default 32: message width in bits.
REQ-003 Port clk, input, 1: sole clock; all state updates on posedge clk.
REQ-004 Port rst, input, 1: reset, synchronous and active-low; state resets at posedge clk while rst==0.
REQ-005 Port req_msg, input, p_num_reqs x p_msg_bits: per-requester message.
REQ-006 Port req_val, input, p_num_reqs: per-requester valid.
REQ-007 Port req_rdy, output, p_num_reqs: per-requester ready; transfer on requester i when req_val[i] & req_rdy[i] at posedge.
REQ-008 Port out_msg, output, p_msg_bits: buffered winning message.
REQ-009 Port out_id, output, $clog2(p_num_reqs): index of requester that supplied out_msg.
REQ-010 Port out_val, output, 1: output buffer holds a message.
REQ-011 Port out_rdy, input, 1: sink ready; drain when out_val & out_rdy at posedge.

Function
REQ-012 Internal state SHALL be: one-entry output buffer (full flag, msg, id) and round-robin pointer ptr, $clog2(p_num_reqs) bits.
REQ-013 accept = rst & (!full | out_rdy); buffer may fill in the same cycle it drains.
REQ-014 When accept, the grant SHALL go to the first i with req_val[i]==1, searching ptr, ptr+1, ... modulo p_num_reqs.
REQ-015 req_rdy SHALL be one-hot or zero: only the granted index high; all zero when !accept or no req_val set.
REQ-016 req_rdy SHALL depend only on req_val, out_rdy, full, ptr, rst -- never on req_msg.
REQ-017 On a grant to i: buffer <= {req_msg[i], i}, full <= 1, ptr <= (i+1) mod p_num_reqs, wrap from p_num_reqs-1 to 0.
REQ-018 Drain without a new grant: full <= 0; ptr unchanged.
REQ-019 No grant: ptr unchanged.
REQ-020 Latency SHALL be exactly 1 cycle from request transfer to out_val; sustained throughput 1 message/cycle when out_rdy held high.
REQ-021 out_val = full; out_msg and out_id SHALL hold stable while out_val & !out_rdy.
REQ-022 A requester whose req_val stays high SHALL be granted within p_num_reqs accepting cycles (starvation-free).
REQ-023 Messages from a single requester SHALL leave in arrival order; no message dropped or duplicated.

Reset
REQ-024 While rst==0 at posedge: full <= 0, ptr <= 0, buffer msg <= 0, buffer id <= 0.
REQ-025 While rst==0: req_rdy SHALL be all 0 and out_val 0, combinationally, regardless of inputs.
REQ-026 Reset mid-operation SHALL discard any buffered message; first grant after reset searches from index 0.

Verification (p_num_reqs=4, p_msg_bits=32)
REQ-027 Reset: hold rst=0 two cycles with all req_val=1 -> req_rdy=0000, out_val=0; release -> first grant to req 0.
REQ-028 All four valid continuously, out_rdy=1, req i sends 0x100+i -> out_id sequence 0,1,2,3,0,... one per cycle, out_msg 0x100..0x103.
REQ-029 Backpressure: buffer holds 0xA from req 1, out_rdy=0 for 3 cycles -> out_msg=0xA, out_id=1 stable, req_rdy=0000; out_rdy=1 -> drains and same-cycle grant refills.
REQ-030 Pointer skip: ptr=2 after grant to req 1, only req 0 and req 3 valid -> req 3 granted, then req 0 (wrap).
REQ-031 Idle then single: no req_val for 5 cycles -> out_val=0, ptr unchanged; req 2 sends 0xDEADBEEF -> out_val next cycle with out_id=2.
REQ-032 Random: random req_val/out_rdy delays (0-3 cycles, TestOstream sink) for 1000 messages -> per-requester order preserved, no loss, each waiting requester granted within 4 accepts.
